// File: rtl/bin2bcd_serial_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
//   - FSM state encoding (2 bits; the unused code 2'd3 falls back to IDLE)
//   - BCD digit width
//   - clog2 helper used to size the shift counter
package bin2bcd_serial_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int BCD_DIGIT_W = 4;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_serial_bcd_add3.sv
// Combinational double-dabble digit corrector.
// Ports:
//   digit     - 4-bit working BCD digit
//   corrected - digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_add3
  import bin2bcd_serial_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  // Adding 3 before the shift makes a digit >= 5 carry into the next digit
  // once it is doubled; the 4-bit add never overflows because digit <= 9.
  assign corrected = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_serial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous active-high reset, aborts any conversion
//   start    - conversion request, only honoured while idle
//   bin      - binary value, captured on the edge that accepts start
//   busy     - high while bits are being shifted
//   done     - one-cycle pulse when bcd/overflow have just been updated
//   bcd      - DIGITS packed BCD digits, digit 0 (units) in bits [3:0]
//   overflow - value did not fit in DIGITS digits (bcd holds value mod 10^DIGITS)
module bin2bcd_serial
  import bin2bcd_serial_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(WIDTH + 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [BCD_W-1:0] work_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sticky_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic             overflow_reg;

  logic [BCD_W-1:0] work_adj;
  logic [BCD_W-1:0] work_next;
  logic [WIDTH-1:0] bin_next;
  logic             sticky_next;
  logic             last_shift;

  // Per-digit add-3 correction applied to the working register before shifting.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .digit     (work_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (work_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // One-bit left shift of {corrected BCD, binary}. The bit leaving the top
  // digit is a carry beyond the displayable range, so it feeds the sticky flag.
  always_comb begin
    work_next   = {work_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
    bin_next    = {bin_reg[WIDTH-2:0], 1'b0};
    sticky_next = sticky_reg | work_adj[BCD_W-1];
    last_shift  = (cnt_reg == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      work_reg     <= '0;
      cnt_reg      <= '0;
      sticky_reg   <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg    <= bin;
            work_reg   <= '0;
            sticky_reg <= 1'b0;
            cnt_reg    <= CNT_W'(WIDTH);
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          work_reg   <= work_next;
          bin_reg    <= bin_next;
          sticky_reg <= sticky_next;
          cnt_reg    <= cnt_reg - CNT_W'(1);
          // Results are published only here, so bcd stays stable otherwise.
          if (last_shift) begin
            bcd_reg      <= work_next;
            overflow_reg <= sticky_next;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_reg == SHIFT);
  assign done     = (state_reg == DONE);
  assign bcd      = bcd_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: a 16-bit/5-digit instance and an
// 8-bit/2-digit instance, table vectors, random values against a decimal
// arithmetic model, and hand-written abort / ignored-start / hold sequences.
module tb_bin2bcd_serial;

  logic        clk;
  logic        reset;
  logic        start16, start8;
  logic [15:0] bin16;
  logic [7:0]  bin8;
  logic        busy16, done16, overflow16;
  logic        busy8, done8, overflow8;
  logic [19:0] bcd16;
  logic [7:0]  bcd8;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_serial #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .start    (start16),
    .bin      (bin16),
    .busy     (busy16),
    .done     (done16),
    .bcd      (bcd16),
    .overflow (overflow16)
  );

  bin2bcd_serial #(.WIDTH(8), .DIGITS(2)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .start    (start8),
    .bin      (bin8),
    .busy     (busy8),
    .done     (done8),
    .bcd      (bcd8),
    .overflow (overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w8;
    int unsigned bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal model: peel off base-10 digits; anything left over is overflow.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits, output logic ovf);
    logic [31:0] r;
    int unsigned rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < digits; k++) begin
      r[k*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    ovf = (rem != 0);
    return r;
  endfunction

  // Starts one conversion from IDLE and returns once the DUT is back in IDLE.
  // edges counts rising edges from the accepting edge (inclusive) to the one
  // that raises done.
  task automatic run_conv(input bit w8, input int unsigned v,
                          output logic [31:0] bcd_o, output logic ovf_o,
                          output int edges, output int busy_cycles);
    @(negedge clk);
    if (w8) begin bin8 = v[7:0]; start8 = 1'b1; end
    else    begin bin16 = v[15:0]; start16 = 1'b1; end
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
    edges = 1;
    busy_cycles = (w8 ? busy8 : busy16) ? 1 : 0;
    while (!(w8 ? done8 : done16) && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      busy_cycles += (w8 ? busy8 : busy16) ? 1 : 0;
    end
    bcd_o = w8 ? {24'h0, bcd8} : {12'h0, bcd16};
    ovf_o = w8 ? overflow8 : overflow16;
    @(posedge clk); #1;
    check(w8 ? "done_pulse8" : "done_pulse16", {31'h0, (w8 ? done8 : done16)}, 32'h0);
    $display("conv w%0d bin=%0d bcd=%h ovf=%0d edges=%0d busy=%0d",
             w8 ? 8 : 16, v, bcd_o, ovf_o, edges, busy_cycles);
  endtask

  initial begin
    logic [31:0] got_bcd, exp_bcd;
    logic        got_ovf, exp_ovf;
    int          edges, busy_cycles, dones, busy_seen, cyc;
    int unsigned v;

    vecs[0] = '{1'b0, 0,     32'h00000, 1'b0};
    vecs[1] = '{1'b0, 65535, 32'h65535, 1'b0};
    vecs[2] = '{1'b0, 9999,  32'h09999, 1'b0};
    vecs[3] = '{1'b0, 10,    32'h00010, 1'b0};
    vecs[4] = '{1'b1, 255,   32'h55,    1'b1};
    vecs[5] = '{1'b1, 99,    32'h99,    1'b0};
    vecs[6] = '{1'b1, 100,   32'h00,    1'b1};

    reset = 1'b1; start16 = 1'b0; start8 = 1'b0; bin16 = '0; bin8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state16", {20'h0, busy16, done16, overflow16, bcd16[8:0]}, 32'h0);
    check("reset_bcd16", {12'h0, bcd16}, 32'h0);
    check("reset_state8", {21'h0, busy8, done8, overflow8, bcd8}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors, including latency and busy-length checks.
    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].w8, vecs[i].bin, got_bcd, got_ovf, edges, busy_cycles);
      check($sformatf("vec%0d_bcd", i), got_bcd, vecs[i].bcd);
      check($sformatf("vec%0d_ovf", i), {31'h0, got_ovf}, {31'h0, vecs[i].ovf});
      check($sformatf("vec%0d_latency", i), edges, vecs[i].w8 ? 9 : 17);
      check($sformatf("vec%0d_busy", i), busy_cycles, vecs[i].w8 ? 8 : 16);
    end

    // Random values against the decimal model.
    for (int i = 0; i < 24; i++) begin
      bit w8;
      w8 = (i >= 16);
      v  = w8 ? $urandom_range(0, 255) : $urandom_range(0, 65535);
      run_conv(w8, v, got_bcd, got_ovf, edges, busy_cycles);
      exp_bcd = ref_bcd(v, w8 ? 2 : 5, exp_ovf);
      check($sformatf("rand%0d_bcd", i), got_bcd, exp_bcd);
      check($sformatf("rand%0d_ovf", i), {31'h0, got_ovf}, {31'h0, exp_ovf});
    end

    // Starts during SHIFT and DONE must be ignored without queueing.
    dones = 0; busy_seen = 0;
    @(negedge clk); bin16 = 16'd1234; start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (done16) dones++; end
    @(negedge clk); bin16 = 16'd4321; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    if (done16) dones++;
    start16 = 1'b1;  // present throughout the DONE cycle
    @(posedge clk); #1; start16 = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done16) dones++;
      if (busy16) busy_seen++;
    end
    $display("ignored-start seq: dones=%0d bcd=%h busy_after=%0d", dones, bcd16, busy_seen);
    check("ignore_done_count", dones, 1);
    check("ignore_bcd", {12'h0, bcd16}, 32'h01234);
    check("ignore_no_restart", busy_seen, 0);
    run_conv(1'b0, 4321, got_bcd, got_ovf, edges, busy_cycles);
    check("fresh_bcd", got_bcd, 32'h04321);

    // Reset on the 7th shift edge of a conversion aborts it.
    @(negedge clk); bin16 = 16'd500; start16 = 1'b1;
    @(posedge clk); #1; start16 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("abort_state", {29'h0, busy16, done16, overflow16}, 32'h0);
    check("abort_bcd", {12'h0, bcd16}, 32'h0);
    dones = 0;
    repeat (30) begin @(posedge clk); #1; if (done16 || busy16) dones++; end
    $display("abort seq: activity_after_reset=%0d", dones);
    check("abort_no_done", dones, 0);
    run_conv(1'b0, 500, got_bcd, got_ovf, edges, busy_cycles);
    check("after_abort_bcd", got_bcd, 32'h00500);

    // Results hold while idle regardless of bin.
    run_conv(1'b0, 42, got_bcd, got_ovf, edges, busy_cycles);
    check("hold_init_bcd", got_bcd, 32'h00042);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); bin16 = 16'($urandom_range(0, 65535)); start16 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("hold%0d", i), {10'h0, done16, overflow16, bcd16}, {10'h0, 1'b0, 1'b0, 20'h00042});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_serial.md
Name: bin2bcd_serial

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It sits directly upstream of the per-digit 7-segment hex decoders. It turns a binary value (counter, register readout, ALU result) into decimal digits, each 4-bit digit driving one decoder's hex_digit input. It uses a start/busy/done handshake and holds the result stable between conversions so the displays never flicker.

Parameters:
WIDTH, 16, bit width of the binary input (>= 2).
DIGITS, 5, number of BCD output digits (>= 1); 10^DIGITS may be smaller than 2^WIDTH, in which case overflow is reported.

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising clk edge where it is high
start  input  1  request conversion; sampled only when idle
bin  input  WIDTH  binary value; captured on the edge that accepts start, ignored otherwise
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/overflow are updated
bcd  output  4*DIGITS  result; digit k occupies bits [4k+3:4k], digit 0 = units
overflow  output  1  value did not fit in DIGITS digits; valid with bcd

Behaviour:
- Reset: state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift/count registers cleared. Reset mid-conversion aborts it; no done pulse is produced for the aborted request.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0. On an edge with start=1: load bin into the shift register, clear the working BCD register and sticky overflow, set bit counter=WIDTH, go to SHIFT.
- SHIFT: busy=1. Each edge:
  - every working digit >= 5 gets +3 (4-bit add, no carry between digits);
  - shift the {working BCD, binary} concatenation left by 1;
  - OR the bit shifted out of the top digit into sticky overflow;
  - decrement the counter.
  - On the edge that performs the WIDTH-th shift: copy the working BCD into bcd, the sticky flag (including that edge's out-shifted bit) into overflow, and go to DONE.
- DONE: lasts one cycle; done=1, busy=0; next state IDLE. A start present during DONE is ignored; the next start is accepted from IDLE.
- Latency: done is high in the cycle that begins WIDTH+1 edges after the start-accepting edge. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- start while busy=1 or during DONE: ignored, with no queueing. bin changes after acceptance do not affect the result.
- bcd and overflow change only on the edge that raises done or on reset; otherwise they hold. Consumers may read them at any time.
- Overflow case: bcd equals value mod 10^DIGITS and overflow=1. Otherwise overflow=0 and bcd is the exact decimal value; every digit is 0..9.
- Width rules: the working register is 4*DIGITS+WIDTH bits and the counter is clog2(WIDTH+1) bits. No truncation warnings are permitted.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 recovers to IDLE);
  - BCD digit width constant (4);
  - a clog2 helper function used to size the counter.
- One sub-module: bcd_add3, a combinational 4-bit corrector (in >= 5 ? in+3 : in). Instantiate it DIGITS times via generate.

Test Plan:
- WIDTH=16, DIGITS=5: bin=0, start pulse -> done exactly 17 edges after acceptance, bcd=20'h00000, overflow=0, busy high for 16 cycles.
- bin=16'd65535 -> bcd=20'h65535, overflow=0. bin=16'd9999 -> bcd=20'h09999. bin=16'd10 -> bcd=20'h00010.
- Start accepted with bin=1234; pulse start with bin=4321 mid-conversion and during DONE -> a single done, bcd=20'h01234; fresh start in IDLE then yields 20'h04321.
- Instance WIDTH=8, DIGITS=2: bin=8'd255 -> bcd=8'h55, overflow=1. bin=8'd99 -> bcd=8'h99, overflow=0.
- Reset asserted for 1 cycle at shift 7 of a bin=500 conversion -> no done, busy=0, bcd=0 next cycle. A subsequent bin=500 conversion yields 20'h00500.
- Hold check: after done with bcd=20'h00042, 50 idle cycles with random bin and start=0 -> bcd and overflow unchanged, done stays 0.
